// File: rtl/ram_bist.sv
// ram_bist: built-in self-test initiator for a 256x8 synchronous single-port RAM.
// Writes a selectable pattern to every address, then reads all addresses back
// and compares them through a READ_LAT-deep address/valid pipeline.
// Optional macro RAM_BIST_ERRCNT_EN builds the 8-bit saturating mismatch counter;
// without it err_count is tied to 0x00.
// dbg_state exposes the FSM state for observation.
// Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse,
// and results hold from done until the next accepted start or reset.
module ram_bist #(
  parameter int READ_LAT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [1:0] pattern,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_addr,
  output logic [7:0] err_count,
  output logic [7:0] RAM_Din,
  output logic [7:0] RAM_Addr,
  output logic       RAM_EN,
  output logic       RAM_WE,
  input  logic [7:0] RAM_Dout,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(READ_LAT - 1);

  // Data written to / expected from address a under pattern p.
  function automatic logic [7:0] pat_fn(input logic [1:0] p, input logic [7:0] a);
    logic [7:0] r;
    case (p)
      2'b00:   r = 8'h00;
      2'b01:   r = 8'hFF;
      2'b10:   r = a[0] ? 8'hAA : 8'h55;
      default: r = a;
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic       en_q, en_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] fail_addr_q, fail_addr_d;
  logic [1:0] pat_q, pat_d;
  logic [1:0] dcnt_q, dcnt_d;
  logic       pv_q [READ_LAT];
  logic       pv_d [READ_LAT];
  logic [7:0] pa_q [READ_LAT];
  logic [7:0] pa_d [READ_LAT];
  logic       push;
  logic       mismatch;

  // Next-state, RAM port, result and compare-pipeline logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    din_d       = din_q;
    en_d        = 1'b0;
    we_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    pat_d       = pat_q;
    dcnt_d      = dcnt_q;
    push        = 1'b0;

    // The oldest pipeline stage lines up with RAM_Dout for the read it tracks.
    mismatch = pv_q[READ_LAT-1] && (RAM_Dout != pat_fn(pat_q, pa_q[READ_LAT-1]));
    if (mismatch) begin
      pass_d = 1'b0;
      // pass still high means no earlier mismatch in this test.
      if (pass_q) fail_addr_d = pa_q[READ_LAT-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WRITE;
          pat_d       = pattern;
          addr_d      = 8'h00;
          din_d       = pat_fn(pattern, 8'h00);
          en_d        = 1'b1;
          we_d        = 1'b1;
          busy_d      = 1'b1;
          pass_d      = 1'b1;
          fail_addr_d = 8'h00;
        end
      end
      S_WRITE: begin
        en_d = 1'b1;
        if (addr_q == 8'hFF) begin
          state_d = S_READ;
          addr_d  = 8'h00;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + 8'd1;
          din_d  = pat_fn(pat_q, addr_q + 8'd1);
        end
      end
      S_READ: begin
        // The RAM samples addr_q on this edge, so it enters the pipeline now.
        push = 1'b1;
        if (addr_q == 8'hFF) begin
          state_d = S_DRAIN;
          dcnt_d  = 2'd0;
        end else begin
          en_d   = 1'b1;
          addr_d = addr_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pv_d[0] = push;
    pa_d[0] = addr_q;
    for (int i = 1; i < READ_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
  end

  // State, RAM port and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      addr_q      <= 8'h00;
      din_q       <= 8'h00;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= 8'h00;
      pat_q       <= 2'b00;
      dcnt_q      <= 2'd0;
      for (int i = 0; i < READ_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      en_q        <= en_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      pat_q       <= pat_d;
      dcnt_q      <= dcnt_d;
      for (int i = 0; i < READ_LAT; i++) begin
        pv_q[i] <= pv_d[i];
        pa_q[i] <= pa_d[i];
      end
    end
  end

`ifdef RAM_BIST_ERRCNT_EN
  logic [7:0] err_q, err_d;

  // Saturating mismatch counter, cleared when a test is accepted.
  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    if ((state_q == S_IDLE) && start) err_d = 8'h00;
  end

  // Mismatch counter register.
  always_ff @(posedge CLK) begin
    if (RST) err_q <= 8'h00;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign RAM_Din   = din_q;
  assign RAM_Addr  = addr_q;
  assign RAM_EN    = en_q;
  assign RAM_WE    = we_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: self-checking bench for ram_bist with READ_LAT=1 (fault-injecting
// RAM model) and READ_LAT=3 (clean RAM model) instances.
module tb_ram_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start3;
  logic [1:0] pattern1, pattern3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [7:0] fail_addr1, err_count1, fail_addr3, err_count3;
  logic [7:0] ram_din1, ram_addr1, ram_dout1, ram_din3, ram_addr3, ram_dout3;
  logic       ram_en1, ram_we1, ram_en3, ram_we3;
  logic [2:0] dbg_state1, dbg_state3;

  int checks = 0;
  int errors = 0;

  // Fault injection on the READ_LAT=1 read path.
  int         fmode = 0;   // 0 none, 1 bit0 high at 0x10, 2 bit7 low, 3 flip bit at faddr
  logic [7:0] faddr = 8'h00;
  int         fbit  = 0;

  ram_bist #(.READ_LAT(1)) dut1 (
    .CLK(clk), .RST(rst), .start(start1), .pattern(pattern1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_addr(fail_addr1),
    .err_count(err_count1), .RAM_Din(ram_din1), .RAM_Addr(ram_addr1),
    .RAM_EN(ram_en1), .RAM_WE(ram_we1), .RAM_Dout(ram_dout1), .dbg_state(dbg_state1)
  );

  ram_bist #(.READ_LAT(3)) dut3 (
    .CLK(clk), .RST(rst), .start(start3), .pattern(pattern3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_addr(fail_addr3),
    .err_count(err_count3), .RAM_Din(ram_din3), .RAM_Addr(ram_addr3),
    .RAM_EN(ram_en3), .RAM_WE(ram_we3), .RAM_Dout(ram_dout3), .dbg_state(dbg_state3)
  );

  function automatic logic [7:0] pat_of(input logic [1:0] p, input int a);
    case (p)
      2'b00:   return 8'h00;
      2'b01:   return 8'hFF;
      2'b10:   return ((a % 2) == 1) ? 8'hAA : 8'h55;
      default: return 8'(a);
    endcase
  endfunction

  function automatic logic [7:0] fault(input logic [7:0] d, input logic [7:0] a,
                                       input int m, input logic [7:0] fa, input int fb);
    logic [7:0] r;
    r = d;
    case (m)
      1: if (a == 8'h10) r[0] = 1'b1;
      2: r[7] = 1'b0;
      3: if (a == fa) r[fb] = ~r[fb];
      default: ;
    endcase
    return r;
  endfunction

  // RAM models: 1-cycle read for dut1, 3-cycle read for dut3.
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] rd1, ra1;
  logic [7:0] rp3 [3];

  always @(posedge clk) begin
    if (ram_en1 && ram_we1) mem1[ram_addr1] <= ram_din1;
    if (ram_en1 && !ram_we1) begin
      rd1 <= mem1[ram_addr1];
      ra1 <= ram_addr1;
    end
    if (ram_en3 && ram_we3) mem3[ram_addr3] <= ram_din3;
    if (ram_en3 && !ram_we3) rp3[0] <= mem3[ram_addr3];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  assign ram_dout1 = fault(rd1, ra1, fmode, faddr, fbit);
  assign ram_dout3 = rp3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic s, input logic [1:0] p);
    if (sel == 0) begin start1 = s; pattern1 = p; end
    else          begin start3 = s; pattern3 = p; end
  endtask

  // One full test on instance sel; optional ignored re-start at cycle re_at.
  task automatic run_test(input int sel, input string tag, input logic [1:0] pat,
                          input int re_at, input logic [1:0] re_pat);
    int lat, busy_bad, done_cnt, done_n, cnt, first, mem_bad;
    logic b, d, pass_at_done;
    logic [7:0] rv, efa, eerr;
    lat = (sel == 0) ? 1 : 3;
    busy_bad = 0; done_cnt = 0; done_n = -1; pass_at_done = 1'bx;
    @(negedge clk);
    set_start(sel, 1'b1, pat);
    for (int n = 1; n <= 518 + lat; n++) begin
      @(negedge clk);
      if (n == 1) set_start(sel, 1'b0, 2'($urandom));
      if (n == re_at) set_start(sel, 1'b1, re_pat);
      else if (n == re_at + 1) set_start(sel, 1'b0, re_pat);
      b = (sel == 0) ? busy1 : busy3;
      d = (sel == 0) ? done1 : done3;
      if (b !== (n <= 512 + lat)) busy_bad++;
      if (d === 1'b1) begin
        done_cnt++;
        done_n = n;
        pass_at_done = (sel == 0) ? pass1 : pass3;
      end
    end
    // Reference: every address stores pat_of; read-back passes through the fault.
    cnt = 0; first = -1; mem_bad = 0;
    for (int a = 0; a < 256; a++) begin
      rv = (sel == 0) ? fault(pat_of(pat, a), 8'(a), fmode, faddr, fbit) : pat_of(pat, a);
      if (rv != pat_of(pat, a)) begin
        cnt++;
        if (first < 0) first = a;
      end
      if (((sel == 0) ? mem1[a] : mem3[a]) !== pat_of(pat, a)) mem_bad++;
    end
    efa = (first < 0) ? 8'h00 : 8'(first);
`ifdef RAM_BIST_ERRCNT_EN
    eerr = (cnt > 255) ? 8'hFF : 8'(cnt);
`else
    eerr = 8'h00;
`endif
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_n), 32'(513 + lat));
    chk({tag, "_pass_at_done"}, 32'(pass_at_done), 32'(cnt == 0));
    chk({tag, "_pass"}, 32'((sel == 0) ? pass1 : pass3), 32'(cnt == 0));
    chk({tag, "_fail_addr"}, 32'((sel == 0) ? fail_addr1 : fail_addr3), 32'(efa));
    chk({tag, "_err_count"}, 32'((sel == 0) ? err_count1 : err_count3), 32'(eerr));
    chk({tag, "_mem"}, 32'(mem_bad), 32'd0);
  endtask

  initial begin
    int found, cnt;
    rst = 1'b1;
    start1 = 1'b0; start3 = 1'b0; pattern1 = 2'b00; pattern3 = 2'b00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_fail_addr", 32'(fail_addr1), 32'd0);
    chk("rst_err_count", 32'(err_count1), 32'd0);
    chk("rst_en_we", 32'({ram_en1, ram_we1}), 32'd0);
    chk("rst_addr_din", 32'({ram_addr1, ram_din1}), 32'd0);
    rst = 1'b0;

    // Clean run, data = address
    fmode = 0;
    run_test(0, "clean", 2'b11, -10, 2'b00);
    chk("clean_mem37", 32'(mem1[8'h37]), 32'h37);

    // Single injected fault at 0x10
    fmode = 1;
    run_test(0, "single", 2'b00, -10, 2'b00);

    // Global stuck-at-0 on bit 7
    fmode = 2;
    run_test(0, "stuck_p10", 2'b10, -10, 2'b00);
    run_test(0, "stuck_p01", 2'b01, -10, 2'b00);

    // Start re-pulsed mid-test must be ignored
    fmode = 0;
    run_test(0, "ignored", 2'b11, 300, 2'b01);

    // Randomized pattern / fault runs
    for (int r = 0; r < 4; r++) begin
      fmode = int'($urandom_range(0, 3));
      faddr = 8'($urandom);
      fbit  = int'($urandom_range(0, 7));
      run_test(0, "rand", 2'($urandom_range(0, 3)), -10, 2'b00);
    end

    // Reset in the middle of WRITE at address 0x80
    fmode = 0;
    @(negedge clk);
    start1 = 1'b1; pattern1 = 2'($urandom);
    @(negedge clk);
    start1 = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      if (ram_addr1 == 8'h80 && ram_we1 === 1'b1) found = 1;
      else @(negedge clk);
    end
    chk("mrst_reached_0x80", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_en_we", 32'({ram_en1, ram_we1}), 32'd0);
    chk("mrst_busy", 32'(busy1), 32'd0);
    chk("mrst_pass_fail", 32'({pass1, fail_addr1}), 32'd0);
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || busy1 !== 1'b0) cnt++;
    end
    chk("mrst_no_done", 32'(cnt), 32'd0);
    run_test(0, "after_rst", 2'($urandom_range(0, 3)), -10, 2'b00);

    // Reset and start on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1; start1 = 1'b1; pattern1 = 2'b11;
    @(negedge clk);
    rst = 1'b0; start1 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy1 !== 1'b0 || ram_en1 !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("rst_start_ignored", 32'(cnt), 32'd0);

    // Longer read latency
    run_test(1, "lat3", 2'($urandom_range(0, 3)), -10, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
